// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared encodings and FSM state type for the radix-4 Booth accumulator
package booth_pkg;

  localparam logic [1:0] OP_ZERO = 2'd0;
  localparam logic [1:0] OP_A    = 2'd1;
  localparam logic [1:0] OP_2A   = 2'd2;
  localparam logic [1:0] OP_ILL  = 2'd3;

  localparam logic SGN_ADD = 1'b0;
  localparam logic SGN_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - combinational signed partial product for one Booth digit
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]        a,
  input  logic [1:0]          op,
  input  logic                sign,
  output logic signed [N+1:0] pp,
  output logic                illegal
);

  logic [N+1:0] mag;

  always_comb begin
    mag     = '0;
    illegal = 1'b0;
    case (op)
      OP_A:    mag = {{2{a[N-1]}}, a};
      OP_2A:   mag = {a[N-1], a, 1'b0};
      OP_ILL:  illegal = 1'b1;
      default: mag = '0;
    endcase
  end

  // Negation as invert plus carry-in; a zero magnitude negates to zero.
  assign pp = (sign == SGN_SUB) ? $signed(~mag + (N+2)'(1)) : $signed(mag);

endmodule

// File: rtl/booth_r4_accum.sv
// rtl/booth_r4_accum.sv - sequential accumulator of radix-4 Booth digits producing a 2N-bit product
module booth_r4_accum
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic           dig_valid,
  input  logic [1:0]     dig_op,
  input  logic           dig_sign,
  output logic           dig_ready,
  output logic [2*N-1:0] prod,
  output logic           done,
  output logic           busy,
  output logic           err
);

  localparam int            ND   = N / 2;
  localparam int            CW   = $clog2(ND);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  state_t           state_q, state_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d;
  logic             err_q, err_d;

  logic signed [N+1:0] pp;
  logic                illegal;
  logic [2*N-1:0]      pp_ext;
  logic [2*N-1:0]      pp_wt;

  booth_pp_gen #(.N(N)) u_pp_gen (
    .a       (a_q),
    .op      (dig_op),
    .sign    (dig_sign),
    .pp      (pp),
    .illegal (illegal)
  );

  // Digit i carries weight 4^i, i.e. a left shift of 2*i.
  assign pp_ext = {{(N-2){pp[N+1]}}, pp};
  assign pp_wt  = pp_ext << {cnt_q, 1'b0};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (dig_valid) begin
          acc_d = acc_q + pp_wt;
          cnt_d = cnt_q + 1'b1;
          if (illegal) err_d = 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  assign prod      = acc_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dig_ready = (state_q == RUN);
  assign err       = err_q;

endmodule

// File: tb/tb_booth_r4_accum.sv
// tb/tb_booth_r4_accum.sv - scoreboard bench for booth_r4_accum with directed and recoded random vectors
module tb_booth_r4_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic        dig_valid = 1'b0;
  logic [1:0]  dig_op = '0;
  logic        dig_sign = 1'b0;
  logic        dig_ready;
  logic [15:0] prod;
  logic        done;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  booth_r4_accum #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .dig_valid (dig_valid),
    .dig_op    (dig_op),
    .dig_sign  (dig_sign),
    .dig_ready (dig_ready),
    .prod      (prod),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("prod", 32'(prod), 32'(e[15:0]));
        check("err_at_done", 32'(err), 32'(e[16]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 20 && busy; t++) tick();
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic feed_digit(input logic [2:0] d);
    dig_valid = 1'b1;
    {dig_op, dig_sign} = d;
    for (int t = 0; t < 20 && !dig_ready; t++) tick();
    if (!dig_ready) check("ready_timeout", 32'(dig_ready), 32'd1);
    tick();
    dig_valid = 1'b0;
  endtask

  // digs holds four {op,sign} triples, digit 0 in the low bits.
  task automatic run_op(input logic [7:0] av, input logic [11:0] digs, input int gap_max,
                        input logic [15:0] exp_p, input logic exp_e, input bit start_noise);
    wait_idle();
    exp_q.push_back({exp_e, exp_p});
    start = 1'b1;
    a     = av;
    tick();
    start = start_noise;
    check("prod_cleared_on_start", 32'(prod), 32'd0);
    check("err_cleared_on_start", 32'(err), 32'd0);
    check("busy_in_run", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        dig_valid = 1'b0;
        dig_op    = 2'($urandom);
        dig_sign  = 1'($urandom);
        check("ready_during_gap", 32'(dig_ready), 32'd1);
        tick();
      end
      feed_digit(digs[3*i +: 3]);
    end
    check("done_after_last_digit", 32'(done), 32'd1);
    check("ready_low_in_done", 32'(dig_ready), 32'd0);
    tick();
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  function automatic logic [11:0] recode(input logic [7:0] b);
    logic [8:0]  bx;
    logic [2:0]  trip;
    logic [11:0] r;
    bx = {b, 1'b0};
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      trip = bx[2*i+2 -: 3];
      case (trip)
        3'b000, 3'b111: r[3*i +: 3] = {2'd0, trip[2]};
        3'b001, 3'b010: r[3*i +: 3] = {2'd1, 1'b0};
        3'b011:         r[3*i +: 3] = {2'd2, 1'b0};
        3'b100:         r[3*i +: 3] = {2'd2, 1'b1};
        default:        r[3*i +: 3] = {2'd1, 1'b1};
      endcase
    end
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_prod"}, 32'(prod), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(dig_ready), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rp;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // 7 * 3 = 21, back-to-back digits
    run_op(8'd7, {3'b000, 3'b000, 3'b010, 3'b011}, 0, 16'h0015, 1'b0, 1'b0);
    // -128 * -128 = 16384, 2A subtract on the top digit
    run_op(8'h80, {3'b101, 3'b000, 3'b000, 3'b000}, 0, 16'h4000, 1'b0, 1'b0);
    // 7 * 3 again with 0..3 idle cycles between digits
    run_op(8'd7, {3'b000, 3'b000, 3'b010, 3'b011}, 3, 16'h0015, 1'b0, 1'b0);
    // illegal first digit: contributes 0, 5 * 4 = 20, err sticky
    run_op(8'd5, {3'b000, 3'b000, 3'b010, 3'b110}, 0, 16'h0014, 1'b1, 1'b0);
    check("err_sticky_in_idle", 32'(err), 32'd1);
    tick();
    check("err_still_sticky", 32'(err), 32'd1);

    // abort mid-operation with reset
    wait_idle();
    start = 1'b1;
    a     = 8'd3;
    tick();
    start = 1'b0;
    feed_digit(3'b010);
    feed_digit(3'b010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midop_reset");
    tick();
    check("no_run_after_reset", 32'(busy), 32'd0);

    // -1 * -1 = 1 with start held high through RUN and DONE
    run_op(8'hFF, {3'b000, 3'b000, 3'b000, 3'b011}, 0, 16'h0001, 1'b0, 1'b1);
    tick();
    check("no_restart_after_noise", 32'(busy), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = $signed(ra) * $signed(rb);
      run_op(ra, recode(rb), (n % 4 == 0) ? 1 : 0, rp, 1'b0, 1'b0);
    end

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_r4_accum.md
Name: booth_r4_accum

Overview:
- Sequential consumer of radix-4 Booth recoded digits. Each digit is an (op, sign) pair: op 0 = 0, op 1 = A, op 2 = 2A; sign 0 = add, sign 1 = subtract.
- Accepts one digit per handshake, least-significant digit first. Forms each signed partial product of multiplicand A and accumulates it at weight 4^i.
- Emits the 2N-bit signed product after N/2 digits.
- Sits downstream of the Booth recoding unit and closes the sequential multiplier datapath.

Parameters:
- N, 8, multiplicand width in bits; must be even and >= 4. Digit count per operation is N/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE
- a  input  N  signed multiplicand, latched on accepted start
- dig_valid  input  1  digit present on dig_op/dig_sign
- dig_op  input  2  magnitude select: 0=0, 1=A, 2=2A, 3=illegal
- dig_sign  input  1  0=add, 1=subtract
- dig_ready  output  1  block accepts a digit this cycle
- prod  output  2N  signed product
- done  output  1  one-cycle pulse: prod is final
- busy  output  1  operation in progress (RUN or DONE)
- err  output  1  sticky flag: illegal digit seen in current operation

Behaviour:
- Reset (rst=1 at clk edge), effective in any state including mid-operation:
  - state=IDLE, accumulator=0, digit count=0, latched A=0.
  - prod=0, done=0, busy=0, dig_ready=0, err=0.
  - Any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - dig_ready=0; digits are ignored.
  - On start=1: latch a, clear accumulator, count and err, go to RUN next cycle.
  - prod holds the previous result until that start is accepted, then reads 0.
- RUN:
  - dig_ready=1 and busy=1.
  - A digit is accepted on each cycle with dig_valid=1. Digit index i equals the count before acceptance.
  - Partial product pp = (-1)^sign × m × A, with m=0/1/2 from op. Width N+2 signed, sign-extended before weighting.
  - Accumulator update on acceptance: acc <= acc + (pp << 2i), computed mod 2^2N.
  - Equivalent implementations (e.g. add to the upper slice, then arithmetic shift right by 2) are allowed if prod is bit-identical.
  - op=0 with sign=1 contributes 0.
  - op=3: contributes 0, sets err. The digit still counts.
  - dig_valid=0 cycles stall: no state change, no timeout.
  - start is ignored while in RUN.
  - After the N/2-th digit is accepted, go to DONE next cycle.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, dig_ready=0.
  - prod equals the final accumulator from the DONE cycle onward.
  - Then IDLE. start during DONE is ignored; a new start is accepted in the following IDLE cycle at the earliest.
- Latency:
  - Minimum: 1 cycle from start to RUN, plus N/2 digit cycles, plus 1 DONE cycle.
  - done asserts the cycle after the last digit is accepted.
- prod, done, busy, dig_ready and err are registered or decoded from the state register only; no combinational path from inputs to outputs.
- Result equals signed a × B, where B is the multiplier the digit stream encodes (mod 2^2N; exact for N-bit signed operands).

Decomposition:
- Package booth_pkg:
  - Op encodings: OP_ZERO=2'd0, OP_A=2'd1, OP_2A=2'd2, OP_ILL=2'd3.
  - Sign encodings: SGN_ADD=1'b0, SGN_SUB=1'b1.
  - State enum: IDLE, RUN, DONE.
- One sub-module, booth_pp_gen: combinational.
  - Inputs: A (N), op, sign.
  - Outputs: pp (N+2 signed) and illegal flag.
  - Implements negation as invert plus carry-in.
- Accumulator, counter and FSM stay in booth_r4_accum.

Test Plan:
- N=8, a=7, digits (1,1),(1,0),(0,0),(0,0), i.e. B=3, streamed back-to-back -> done one cycle after the 4th digit, prod=21 (0x0015), err=0.
- a=-128, digits (0,0),(0,0),(0,0),(2,1), i.e. B=-128 -> prod=16384 (0x4000); checks the 2A subtract boundary.
- a=7, same digits as the first scenario with dig_valid=0 gaps of 0-3 random cycles -> same prod=21; dig_ready stays 1 throughout RUN; no digit is lost or duplicated.
- a=5, digits (3,0),(1,0),(0,0),(0,0) -> err=1 from the 1st digit until the next start; prod=20; the next clean operation clears err.
- rst pulsed after the 2nd digit, then start with a=-1 and digits for B=-1, i.e. (1,1),(0,0),(0,0),(0,0) -> all outputs 0 after reset; prod=1; start pulses during RUN/DONE are ignored.
- Random a and B over 1000 operations (digits generated by the recoding rule, B's sign bit included) -> prod == a×B sign-extended to 16 bits every time.
